ex_mem_flag_stage: RTL and testbench

//  EX->MEM pipeline register directly downstream of the ALU/PADDSB datapath.

---
 rtl/ex_mem_flag_stage_pkg.sv | 44 ++++
 rtl/ex_mem_flag_stage_if.sv | 27 ++
 rtl/ex_mem_flag_stage_flag_unit.sv | 56 +++++
 rtl/ex_mem_flag_stage.sv | 126 ++++++++++++
 tb/tb_ex_mem_flag_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared WISC definitions: opcodes, the Z/V/N flag record and the per-opcode flag write mask.
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LLB    = 4'b1010;
   localparam logic [3:0] OP_LHB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   typedef struct packed {
      logic z;
      logic v;
      logic n;
   } flags_t;

   typedef struct packed {
      logic wz;
      logic wv;
      logic wn;
   } flag_mask_t;

   // Arithmetic ops write all flags, logic/shift ops write only Z, the rest leave flags alone.
   function automatic flag_mask_t flag_update_mask(input logic [3:0] opcode);
      flag_mask_t m;
      case (opcode)
         OP_ADD, OP_SUB:                 m = '{wz: 1'b1, wv: 1'b1, wn: 1'b1};
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = '{wz: 1'b1, wv: 1'b0, wn: 1'b0};
         default:                        m = '{wz: 1'b0, wv: 1'b0, wn: 1'b0};
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX->MEM bus: instruction fields leaving EX and the registered MEM-stage copy.
interface ex_mem_flag_stage_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) ();
   logic              ex_valid;
   logic [3:0]        ex_opcode;
   logic [DATA_W-1:0] ex_result;
   logic              ex_ovfl;
   logic [REG_AW-1:0] ex_dst;
   logic              ex_wr_en;

   logic              mem_valid;
   logic [DATA_W-1:0] mem_result;
   logic [REG_AW-1:0] mem_dst;
   logic              mem_wr_en;

   modport master (
      output ex_valid, ex_opcode, ex_result, ex_ovfl, ex_dst, ex_wr_en,
      input  mem_valid, mem_result, mem_dst, mem_wr_en
   );

   modport slave (
      input  ex_valid, ex_opcode, ex_result, ex_ovfl, ex_dst, ex_wr_en,
      output mem_valid, mem_result, mem_dst, mem_wr_en
   );
endinterface

// File: rtl/ex_mem_flag_stage_flag_unit.sv
// Architectural Z/V/N flag register with per-opcode write masks.
// FLAG_BYPASS_EN: nxt_o forwards the flags being written this cycle instead of the registered copy.
module flag_unit
   import wisc_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cap_i,
   input  logic [3:0]        opcode_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic              ovfl_i,
   output flags_t            flags_o,
   output flags_t            nxt_o
);

   flags_t     flags_q;
   flags_t     flags_d;
   flags_t     calc_s;
   flag_mask_t mask_s;

   // Next flags: only masked fields of a captured instruction change.
   always_comb begin
      mask_s   = flag_update_mask(opcode_i);
      calc_s.z = (result_i == {DATA_W{1'b0}});
      calc_s.v = ovfl_i;
      calc_s.n = result_i[DATA_W-1];
      flags_d  = flags_q;
      if (cap_i) begin
         flags_d.z = mask_s.wz ? calc_s.z : flags_q.z;
         flags_d.v = mask_s.wv ? calc_s.v : flags_q.v;
         flags_d.n = mask_s.wn ? calc_s.n : flags_q.n;
      end else begin
         flags_d = flags_q;
      end
   end

   // Flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '{z: 1'b0, v: 1'b0, n: 1'b0};
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_o = flags_q;

`ifdef FLAG_BYPASS_EN
   assign nxt_o = flags_d;
`else
   assign nxt_o = flags_q;
`endif

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register with architectural flags, PADDSB saturation counter and sticky halt.
// Optional FLAG_BYPASS_EN (in flag_unit) forwards same-cycle flag updates onto nxt_z/v/n.
module ex_mem_flag_stage
   import wisc_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int REG_AW   = 4,
   parameter int SATCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                flush,
   ex_mem_flag_stage_if.slave  bus,
   output logic                flag_z,
   output logic                flag_v,
   output logic                flag_n,
   output logic                nxt_z,
   output logic                nxt_v,
   output logic                nxt_n,
   output logic [SATCNT_W-1:0] sat_cnt,
   output logic                halted
);

   logic                cap_s;
   logic                bubble_s;

   logic                mem_valid_q,  mem_valid_d;
   logic [DATA_W-1:0]   mem_result_q, mem_result_d;
   logic [REG_AW-1:0]   mem_dst_q,    mem_dst_d;
   logic                mem_wr_en_q,  mem_wr_en_d;
   logic [SATCNT_W-1:0] sat_cnt_q,    sat_cnt_d;
   logic                halted_q,     halted_d;

   flags_t              flags_s;
   flags_t              nxt_s;

   // Once halted nothing else is captured; flush beats stall, and an idle EX becomes a bubble.
   always_comb begin
      cap_s    = bus.ex_valid & ~stall & ~flush & ~halted_q;
      bubble_s = flush | (~stall & (~bus.ex_valid | halted_q));
   end

   // Pipeline register next state: capture, bubble (data fields hold) or stall hold.
   always_comb begin
      mem_valid_d  = mem_valid_q;
      mem_result_d = mem_result_q;
      mem_dst_d    = mem_dst_q;
      mem_wr_en_d  = mem_wr_en_q;
      if (cap_s) begin
         mem_valid_d  = 1'b1;
         mem_result_d = bus.ex_result;
         mem_dst_d    = bus.ex_dst;
         mem_wr_en_d  = bus.ex_wr_en;
      end else if (bubble_s) begin
         mem_valid_d  = 1'b0;
         mem_wr_en_d  = 1'b0;
      end else begin
         mem_valid_d  = mem_valid_q;
         mem_wr_en_d  = mem_wr_en_q;
      end
   end

   // Saturation counter sticks at all-ones; halt is sticky until reset.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      halted_d  = halted_q;
      if (cap_s && (bus.ex_opcode == OP_PADDSB) && bus.ex_ovfl &&
          (sat_cnt_q != {SATCNT_W{1'b1}})) begin
         sat_cnt_d = sat_cnt_q + {{(SATCNT_W-1){1'b0}}, 1'b1};
      end else begin
         sat_cnt_d = sat_cnt_q;
      end
      if (cap_s && (bus.ex_opcode == OP_HLT)) begin
         halted_d = 1'b1;
      end else begin
         halted_d = halted_q;
      end
   end

   // Stage state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid_q  <= 1'b0;
         mem_result_q <= {DATA_W{1'b0}};
         mem_dst_q    <= {REG_AW{1'b0}};
         mem_wr_en_q  <= 1'b0;
         sat_cnt_q    <= {SATCNT_W{1'b0}};
         halted_q     <= 1'b0;
      end else begin
         mem_valid_q  <= mem_valid_d;
         mem_result_q <= mem_result_d;
         mem_dst_q    <= mem_dst_d;
         mem_wr_en_q  <= mem_wr_en_d;
         sat_cnt_q    <= sat_cnt_d;
         halted_q     <= halted_d;
      end
   end

   flag_unit #(
      .DATA_W (DATA_W)
   ) u_flag_unit (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap_i    (cap_s),
      .opcode_i (bus.ex_opcode),
      .result_i (bus.ex_result),
      .ovfl_i   (bus.ex_ovfl),
      .flags_o  (flags_s),
      .nxt_o    (nxt_s)
   );

   assign bus.mem_valid  = mem_valid_q;
   assign bus.mem_result = mem_result_q;
   assign bus.mem_dst    = mem_dst_q;
   assign bus.mem_wr_en  = mem_wr_en_q;
   assign sat_cnt        = sat_cnt_q;
   assign halted         = halted_q;
   assign flag_z         = flags_s.z;
   assign flag_v         = flags_s.v;
   assign flag_n         = flags_s.n;
   assign nxt_z          = nxt_s.z;
   assign nxt_v          = nxt_s.v;
   assign nxt_n          = nxt_s.n;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Self-checking bench for ex_mem_flag_stage: directed vector table, corner sequences, random vs. reference model.
module tb_ex_mem_flag_stage;

`ifdef FLAG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stall = 1'b0;
   logic       flush = 1'b0;
   logic       flag_z, flag_v, flag_n, nxt_z, nxt_v, nxt_n, halted;
   logic [7:0] sat_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   ex_mem_flag_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

   ex_mem_flag_stage #(.DATA_W(16), .REG_AW(4), .SATCNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus),
      .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
      .nxt_z(nxt_z), .nxt_v(nxt_v), .nxt_n(nxt_n),
      .sat_cnt(sat_cnt), .halted(halted)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic        m_valid, m_wr, m_z, m_v, m_n, m_halt;
   logic [15:0] m_res;
   logic [3:0]  m_dst;
   int          m_cnt;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] res;
      logic        ovfl, valid, stall, flush;
      logic        ez, ev, en, emv;
      logic [15:0] eres;
      logic [7:0]  ecnt;
   } vec_t;
   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] model_flags(input logic [3:0] op, input logic [15:0] res,
                                              input logic ovfl, input logic [2:0] cur);
      logic [2:0] f;
      f = cur;
      if (op == 4'd0 || op == 4'd1) f = {(res == 16'd0), ovfl, res[15]};
      else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) f[2] = (res == 16'd0);
      else f = cur;
      return f;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_wr = 1'b0; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
      m_halt = 1'b0; m_res = 16'd0; m_dst = 4'd0; m_cnt = 0;
   endtask

   task automatic set_in(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic [3:0] dst, input logic wr,
                         input logic st, input logic fl);
      bus.ex_valid = v; bus.ex_opcode = op; bus.ex_result = res; bus.ex_ovfl = ov;
      bus.ex_dst = dst; bus.ex_wr_en = wr; stall = st; flush = fl;
   endtask

   task automatic do_reset();
      set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic check_model();
      chk("mem_valid", {31'd0, bus.mem_valid}, {31'd0, m_valid});
      chk("mem_result", {16'd0, bus.mem_result}, {16'd0, m_res});
      chk("mem_dst", {28'd0, bus.mem_dst}, {28'd0, m_dst});
      chk("mem_wr_en", {31'd0, bus.mem_wr_en}, {31'd0, m_wr});
      chk("flags", {29'd0, flag_z, flag_v, flag_n}, {29'd0, m_z, m_v, m_n});
      chk("sat_cnt", {24'd0, sat_cnt}, m_cnt);
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
   endtask

   // One clock with model: check nxt_* before the edge, state after it.
   task automatic model_cycle();
      logic       cap;
      logic [2:0] nf;
      #1;
      cap = bus.ex_valid && !stall && !flush && !m_halt;
      nf  = model_flags(bus.ex_opcode, bus.ex_result, bus.ex_ovfl, {m_z, m_v, m_n});
      chk("nxt_flags", {29'd0, nxt_z, nxt_v, nxt_n},
          {29'd0, (BYP && cap) ? nf : {m_z, m_v, m_n}});
      if (cap) begin
         m_valid = 1'b1; m_res = bus.ex_result; m_dst = bus.ex_dst; m_wr = bus.ex_wr_en;
         {m_z, m_v, m_n} = nf;
         if (bus.ex_opcode == 4'd7 && bus.ex_ovfl && m_cnt < 255) m_cnt++;
         if (bus.ex_opcode == 4'd15) m_halt = 1'b1;
      end else if (flush || !stall) begin
         m_valid = 1'b0; m_wr = 1'b0;
      end
      @(posedge clk); #1;
      check_model();
   endtask

   initial begin
      set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      // op res ovfl valid stall flush | z v n mv res cnt
      vecs[0]  = '{4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 8'd0};
      vecs[1]  = '{4'd0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 8'd0};
      vecs[2]  = '{4'd2, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 8'd0};
      vecs[3]  = '{4'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 8'd0};
      vecs[4]  = '{4'd1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 8'd0};
      vecs[5]  = '{4'd4, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'd0};
      vecs[6]  = '{4'd3, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 8'd0};
      vecs[7]  = '{4'd7, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'd1};
      vecs[8]  = '{4'd8, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'd1};
      vecs[9]  = '{4'd5, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 8'd1};
      vecs[10] = '{4'd6, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000, 8'd1};
      vecs[11] = '{4'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000, 8'd1};
      vecs[12] = '{4'd1, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000, 8'd1};
      vecs[13] = '{4'd1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7FFF, 8'd1};

      // Reset state
      #2;
      chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      chk("rst_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
      chk("rst_sat_cnt", {24'd0, sat_cnt}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      do_reset();

      // Directed vector table
      for (int i = 0; i < 14; i++) begin
         set_in(vecs[i].valid, vecs[i].op, vecs[i].res, vecs[i].ovfl, i[3:0], 1'b1,
                vecs[i].stall, vecs[i].flush);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_flags", i), {29'd0, flag_z, flag_v, flag_n},
             {29'd0, vecs[i].ez, vecs[i].ev, vecs[i].en});
         chk($sformatf("vec%0d_mem_valid", i), {31'd0, bus.mem_valid}, {31'd0, vecs[i].emv});
         chk($sformatf("vec%0d_mem_wr_en", i), {31'd0, bus.mem_wr_en}, {31'd0, vecs[i].emv});
         chk($sformatf("vec%0d_mem_result", i), {16'd0, bus.mem_result}, {16'd0, vecs[i].eres});
         chk($sformatf("vec%0d_sat_cnt", i), {24'd0, sat_cnt}, {24'd0, vecs[i].ecnt});
      end

      // Bypass visibility: SUB with negative result
      do_reset();
      set_in(1'b1, 4'd1, 16'hFFFE, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
      #1;
      chk("byp_nxt_n_same", {31'd0, nxt_n}, {31'd0, BYP});
      chk("byp_flag_n_same", {31'd0, flag_n}, 32'd0);
      @(posedge clk); #1;
      set_in(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("byp_flag_n_next", {31'd0, flag_n}, 32'd1);
      #1;
      chk("byp_nxt_n_next", {31'd0, nxt_n}, 32'd1);

      // Random traffic against the model, HLT excluded
      do_reset();
      for (int i = 0; i < 600; i++) begin
         set_in($urandom_range(0, 9) != 0, 4'($urandom_range(0, 14)),
                ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
                1'($urandom), 4'($urandom), 1'($urandom),
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
         model_cycle();
      end
      // Stall+flush bubble, then a 3-cycle stall freeze
      set_in(1'b1, 4'd0, 16'h0005, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
      model_cycle();
      set_in(1'b1, 4'd1, 16'h0000, 1'b1, 4'd4, 1'b1, 1'b1, 1'b1);
      model_cycle();
      set_in(1'b1, 4'd0, 16'h0007, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
      model_cycle();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 4'($urandom_range(0, 7)), 16'($urandom), 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
         model_cycle();
      end

      // Saturation counter: 300 PADDSB saturation events
      do_reset();
      set_in(1'b1, 4'd7, 16'h7F80, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
      end
      #1;
      chk("sat_cnt_max", {24'd0, sat_cnt}, 32'h0000_00FF);
      chk("sat_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
      chk("sat_mem_valid", {31'd0, bus.mem_valid}, 32'd1);

      // HLT commits, following ADD is never captured
      set_in(1'b1, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      set_in(1'b1, 4'd15, 16'hABCD, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("hlt_halted", {31'd0, halted}, 32'd1);
      chk("hlt_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
      chk("hlt_mem_result", {16'd0, bus.mem_result}, 32'h0000_ABCD);
      set_in(1'b1, 4'd0, 16'h1111, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("hlt_add_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      chk("hlt_add_mem_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
      chk("hlt_add_mem_result", {16'd0, bus.mem_result}, 32'h0000_ABCD);
      chk("hlt_add_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd6);
      chk("hlt_still_halted", {31'd0, halted}, 32'd1);

      // Asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_halted", {31'd0, halted}, 32'd0);
      chk("arst_sat_cnt", {24'd0, sat_cnt}, 32'd0);
      chk("arst_mem_result", {16'd0, bus.mem_result}, 32'd0);
      chk("arst_mem_dst", {28'd0, bus.mem_dst}, 32'd0);
      chk("arst_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      set_in(1'b1, 4'd0, 16'h8001, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
      model_cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
